// File: rtl/staged_timer_pkg.sv
// Shared types and width helpers for the staged timer and
// the button lockout.
package staged_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    WAIT_REL
  } lock_state_e;

  typedef enum logic {
    DIR_NEXT,
    DIR_PREV
  } dir_e;

  function automatic int unsigned stage_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned shape_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned lock_cnt_w(input int unsigned d);
    return $clog2(d);
  endfunction

endpackage

// File: rtl/btn_lockout.sv
// Press-and-release lockout: one step per press, issued after
// the lockout count has elapsed.
module btn_lockout
  import staged_timer_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 20_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic btn_next,
  input  logic btn_prev,
  output logic step_valid,
  output dir_e step_dir,
  output logic btn_lock
);

  localparam int unsigned LW = lock_cnt_w(DEBOUNCE);
  localparam logic [LW-1:0] LAST = LW'(DEBOUNCE - 1);

  lock_state_e   state_q;
  logic [LW-1:0] cnt_q;
  dir_e          dir_q;
  logic          lock_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_NEXT;
      lock_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (btn_next || btn_prev) begin
            dir_q   <= btn_next ? DIR_NEXT : DIR_PREV;
            lock_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          if (cnt_q == LAST) begin
            state_q <= WAIT_REL;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_REL: begin
          if (!btn_next && !btn_prev) begin
            lock_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Step fires on the edge that leaves COUNT.
  assign step_valid = (state_q == COUNT) && (cnt_q == LAST);
  assign step_dir   = dir_q;
  assign btn_lock   = lock_q;

endmodule

// File: rtl/staged_timer_ctrl.sv
// Staged run timer plus debounced wrapping shape selector
// for the display controller.
module staged_timer_ctrl
  import staged_timer_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned CNT_W      = 32,
  parameter logic [NUM_STAGES*CNT_W-1:0] STAGE_AT =
    {32'd450_000_000, 32'd350_000_000, 32'd200_000_000},
  parameter int unsigned PERIOD     = 550_000_000,
  parameter int unsigned NUM_SHAPES = 3,
  parameter int unsigned DEBOUNCE   = 20_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic arm,
  input  logic loop,
  input  logic hold,
  input  logic btn_next,
  input  logic btn_prev,
  output logic armed,
  output logic [stage_w(NUM_STAGES)-1:0] stage,
  output logic stage_pulse,
  output logic done,
  output logic [shape_w(NUM_SHAPES)-1:0] shape,
  output logic shape_pulse,
  output logic btn_lock
);

  localparam int unsigned SW  = stage_w(NUM_STAGES);
  localparam int unsigned SHW = shape_w(NUM_SHAPES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD);
  localparam logic [SHW-1:0]   SHMAX = SHW'(NUM_SHAPES);

  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [SHW-1:0]   shape_q, shape_d;
  logic             done_q, done_d;
  logic             stage_pulse_q;
  logic             shape_pulse_q;
  logic             step_valid;
  dir_e             step_dir;

  btn_lockout #(
    .DEBOUNCE(DEBOUNCE)
  ) u_lock (
    .clk       (clk),
    .reset     (reset),
    .clear     (!enable),
    .btn_next  (btn_next),
    .btn_prev  (btn_prev),
    .step_valid(step_valid),
    .step_dir  (step_dir),
    .btn_lock  (btn_lock)
  );

  always_comb begin
    armed_d = armed_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    shape_d = shape_q;
    done_d  = 1'b0;
    if (!enable) begin
      armed_d = 1'b0;
      cnt_d   = '0;
      stage_d = '0;
      shape_d = '0;
    end else begin
      if (!armed_q) begin
        armed_d = arm;
        cnt_d   = '0;
        stage_d = '0;
      end else if (!hold) begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          stage_d = '0;
          if (!loop) begin
            armed_d = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          for (int k = 0; k < NUM_STAGES; k++) begin
            if (cnt_q == STAGE_AT[k*CNT_W +: CNT_W])
              stage_d = SW'(k + 1);
          end
        end
      end
      // Steps landing while disarmed are dropped.
      if (step_valid && armed_q) begin
        if (step_dir == DIR_NEXT)
          shape_d = (shape_q >= SHMAX) ? SHW'(1) : shape_q + 1'b1;
        else
          shape_d = (shape_q <= SHW'(1)) ? SHMAX : shape_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q       <= 1'b0;
      cnt_q         <= '0;
      stage_q       <= '0;
      shape_q       <= '0;
      done_q        <= 1'b0;
      stage_pulse_q <= 1'b0;
      shape_pulse_q <= 1'b0;
    end else begin
      armed_q       <= armed_d;
      cnt_q         <= cnt_d;
      stage_q       <= stage_d;
      shape_q       <= shape_d;
      done_q        <= done_d;
      stage_pulse_q <= (stage_d != stage_q);
      shape_pulse_q <= (shape_d != shape_q);
    end
  end

  assign armed       = armed_q;
  assign stage       = stage_q;
  assign stage_pulse = stage_pulse_q;
  assign done        = done_q;
  assign shape       = shape_q;
  assign shape_pulse = shape_pulse_q;

endmodule

// File: tb/tb_staged_timer_ctrl.sv
// Directed bench for staged_timer_ctrl with short stage
// thresholds and a 4-cycle lockout.
module tb_staged_timer_ctrl;

  logic clk = 1'b0;
  logic reset, enable, arm, loop, hold, btn_next, btn_prev;
  logic armed, stage_pulse, done, shape_pulse, btn_lock;
  logic [1:0] stage;
  logic [1:0] shape;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  staged_timer_ctrl #(
    .NUM_STAGES(3),
    .CNT_W     (32),
    .STAGE_AT  ({32'd9, 32'd6, 32'd3}),
    .PERIOD    (12),
    .NUM_SHAPES(3),
    .DEBOUNCE  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .arm        (arm),
    .loop       (loop),
    .hold       (hold),
    .btn_next   (btn_next),
    .btn_prev   (btn_prev),
    .armed      (armed),
    .stage      (stage),
    .stage_pulse(stage_pulse),
    .done       (done),
    .shape      (shape),
    .shape_pulse(shape_pulse),
    .btn_lock   (btn_lock)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic nx, input logic pv);
    btn_next = nx;
    btn_prev = pv;
    repeat (6) tick();
    btn_next = 1'b0;
    btn_prev = 1'b0;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_armed"}, armed, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_spulse"}, stage_pulse, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_shape"}, shape, 0);
    chk({tag, "_hpulse"}, shape_pulse, 0);
    chk({tag, "_lock"}, btn_lock, 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; arm = 1'b0; loop = 1'b0;
    hold = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
    repeat (2) tick();
    chk_all_zero("rst");
    reset = 1'b0;
    enable = 1'b1;
    tick();

    // loop run
    loop = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm_armed", armed, 1);
    chk("arm_stage", stage, 0);
    for (int c = 1; c <= 30; c++) begin
      int m;
      int es;
      int ep;
      tick();
      m  = c % 13;
      es = (m >= 10) ? 3 : (m >= 7) ? 2 : (m >= 4) ? 1 : 0;
      ep = (m == 4 || m == 7 || m == 10 || m == 0) ? 1 : 0;
      chk("loop_stage", stage, es);
      chk("loop_pulse", stage_pulse, ep);
    end
    enable = 1'b0;
    tick();
    chk("dis_armed", armed, 0);
    chk("dis_stage", stage, 0);
    enable = 1'b1;

    // one-shot
    loop = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (12) tick();
    chk("os_stage3", stage, 3);
    chk("os_armed", armed, 1);
    chk("os_nodone", done, 0);
    tick();
    chk("os_end_armed", armed, 0);
    chk("os_done", done, 1);
    chk("os_stage0", stage, 0);
    chk("os_spulse", stage_pulse, 1);
    tick();
    chk("os_done_once", done, 0);
    repeat (5) tick();
    chk("os_idle_armed", armed, 0);
    chk("os_idle_stage", stage, 0);

    // hold in stage 1
    loop = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (4) tick();
    chk("hold_pre", stage, 1);
    hold = 1'b1;
    repeat (20) tick();
    chk("hold_frz", stage, 1);
    chk("hold_nopulse", stage_pulse, 0);
    hold = 1'b0;
    repeat (2) tick();
    chk("hold_late", stage, 1);
    tick();
    chk("hold_st2", stage, 2);
    chk("hold_st2p", stage_pulse, 1);

    // buttons while armed
    btn_next = 1'b1;
    tick();
    chk("bn_lock", btn_lock, 1);
    chk("bn_sh0", shape, 0);
    repeat (3) tick();
    chk("bn_sh0b", shape, 0);
    tick();
    chk("bn_sh1", shape, 1);
    chk("bn_hp", shape_pulse, 1);
    tick();
    chk("bn_hp0", shape_pulse, 0);
    repeat (44) tick();
    chk("bn_held_sh", shape, 1);
    chk("bn_held_lk", btn_lock, 1);
    btn_next = 1'b0;
    tick();
    chk("bn_rel", btn_lock, 0);
    press(1'b1, 1'b0);
    chk("bn_sh2", shape, 2);
    press(1'b0, 1'b1);
    chk("bp_sh1", shape, 1);
    press(1'b0, 1'b1);
    chk("bp_wrap", shape, 3);
    press(1'b1, 1'b1);
    chk("bn_wrap", shape, 1);

    // clear mid-run with lockout in COUNT
    press(1'b1, 1'b0);
    chk("clr_sh2", shape, 2);
    btn_next = 1'b1;
    repeat (2) tick();
    chk("clr_lk", btn_lock, 1);
    enable = 1'b0;
    tick();
    chk("clr_armed", armed, 0);
    chk("clr_stage", stage, 0);
    chk("clr_shape", shape, 0);
    chk("clr_lock", btn_lock, 0);
    enable = 1'b1;
    btn_next = 1'b0;
    tick();
    chk("clr_lock2", btn_lock, 0);

    // press while disarmed
    btn_next = 1'b1;
    tick();
    chk("dp_lock", btn_lock, 1);
    repeat (4) tick();
    chk("dp_shape", shape, 0);
    chk("dp_hp", shape_pulse, 0);
    chk("dp_lock2", btn_lock, 1);
    btn_next = 1'b0;
    tick();
    chk("dp_rel", btn_lock, 0);

    // arm with enable low
    enable = 1'b0;
    arm = 1'b1;
    tick();
    chk("ae_armed", armed, 0);
    enable = 1'b1;
    arm = 1'b0;
    tick();
    chk("ae_armed2", armed, 0);

    // reset mid-run
    arm = 1'b1;
    tick();
    arm = 1'b0;
    press(1'b1, 1'b0);
    chk("mr_shape", shape, 1);
    btn_next = 1'b1;
    tick();
    chk("mr_lock", btn_lock, 1);
    chk("mr_stage", stage, 2);
    reset = 1'b1;
    tick();
    chk_all_zero("mr");
    reset = 1'b0;
    btn_next = 1'b0;
    tick();
    chk("mr_after", armed, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
